// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - ShiftRows byte-map helpers and mode encodings
//
// Purpose: shared constants and elaboration-time index helpers for the
// Rijndael ShiftRows datapath.
//   MODE_FWD / MODE_INV : per-beat mode encodings
//   shift_off(nb, r)    : left-rotation amount of row r for an nb-column state
//   byte_idx(r, c)      : byte position of state element (r,c), column-major
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Rows 2 and 3 of the 256-bit block rotate by 3 and 4 instead of 2 and 3.
  function automatic int shift_off(input int nb, input int r);
    if (nb == 8 && r >= 2) begin
      return r + 1;
    end
    return r;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one elastic valid/ready register stage
//
// Purpose: holds a single payload word with a valid bit; passes ready
// upstream combinationally so a full stage can drain and refill in the
// same cycle.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_flush           : synchronous clear of the valid bit (payload held)
//   i_valid, o_ready  : upstream handshake
//   i_data            : upstream payload
//   o_valid, i_ready  : downstream handshake
//   o_data            : registered payload
module pipe_stage #(
  parameter int PW = 37
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;
  logic          w_load;

  assign o_ready = !r_valid || i_ready;
  // Flush wins over a load that would otherwise happen on the same edge.
  assign w_load  = i_valid && o_ready && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/shiftrows_pipe.sv
// rtl/shiftrows_pipe.sv - pipelined forward/inverse ShiftRows with elastic handshake
//
// Purpose: permutes the state bytes of one Rijndael block per beat, forward or
// inverse as selected by the beat's own mode bit, then registers the result
// through STAGES elastic stages together with the mode and a sideband tag.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   flush                       : synchronous drop of all in-flight beats
//   in_valid, in_ready          : input handshake
//   in_mode, in_data, in_tag    : input beat (mode 0 fwd, 1 inv)
//   out_valid, out_ready        : output handshake
//   out_mode, out_data, out_tag : output beat
//   busy                        : any stage holds a beat
module shiftrows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [0:32*NB-1] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:32*NB-1] out_data,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int W  = 32 * NB;
  localparam int PW = W + 1 + TAG_W;

  logic [0:W-1]  w_fwd;
  logic [0:W-1]  w_inv;
  logic [0:W-1]  w_perm;
  logic [PW-1:0] w_in_pay;

  logic          w_s1_valid;
  logic          w_s1_ready;
  logic          w_s1_down_ready;
  logic [PW-1:0] w_s1_data;
  logic          w_out_valid;
  logic [PW-1:0] w_out_pay;

  // Pure wiring: every source column is a constant resolved per (r,c).
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int DST   = 8 * byte_idx(r, c);
      localparam int SRC_F = 8 * byte_idx(r, (c + shift_off(NB, r)) % NB);
      localparam int SRC_I = 8 * byte_idx(r, (c - shift_off(NB, r) + NB) % NB);
      assign w_fwd[DST +: 8] = in_data[SRC_F +: 8];
      assign w_inv[DST +: 8] = in_data[SRC_I +: 8];
    end
  end

  always_comb begin
    w_perm = w_fwd;
    case (in_mode)
      MODE_FWD: w_perm = w_fwd;
      MODE_INV: w_perm = w_inv;
      default:  w_perm = w_fwd;
    endcase
  end

  assign w_in_pay = {w_perm, in_mode, in_tag};
  assign in_ready = w_s1_ready && !flush;

  pipe_stage #(.PW(PW)) u_stage1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (w_s1_ready),
    .i_data  (w_in_pay),
    .o_valid (w_s1_valid),
    .i_ready (w_s1_down_ready),
    .o_data  (w_s1_data)
  );

  if (STAGES == 2) begin : g_two
    pipe_stage #(.PW(PW)) u_stage2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_valid (w_s1_valid),
      .o_ready (w_s1_down_ready),
      .i_data  (w_s1_data),
      .o_valid (w_out_valid),
      .i_ready (out_ready),
      .o_data  (w_out_pay)
    );
  end else begin : g_one
    assign w_s1_down_ready = out_ready;
    assign w_out_valid     = w_s1_valid;
    assign w_out_pay       = w_s1_data;
  end

  assign out_valid = w_out_valid;
  assign out_data  = w_out_pay[PW-1 -: W];
  assign out_mode  = w_out_pay[TAG_W];
  assign out_tag   = w_out_pay[TAG_W-1:0];
  assign busy      = w_s1_valid || w_out_valid;

endmodule
